// File: rtl/pwl_activation_pipe.sv
// pwl_activation_pipe: pipelined piecewise-linear activation unit.
// Modes: 0 = PLAN sigmoid, 1 = tanh (via sigmoid of 2x), 2 = hard-sigmoid,
// 3 = saturating ReLU. One capture rank followed by three compute ranks
// (segment select, multiply-add, symmetry/clamp). A single enable
// (in_ready) advances or holds every rank together.
module pwl_activation_pipe #(
  parameter int IN_W    = 8,
  parameter int IN_FRAC = 4,
  parameter int OUT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam logic [1:0] M_SIG  = 2'd0;
  localparam logic [1:0] M_TANH = 2'd1;
  localparam logic [1:0] M_HSIG = 2'd2;
  localparam logic [1:0] M_RELU = 2'd3;

  // |v| width, fractional bits of the multiply-add result, accumulator width.
  // Five extra fractional bits keep p/32 and 27/32 exact even at OUT_W = 4.
  localparam int PW = IN_W + 2;
  localparam int FR = OUT_W + IN_FRAC + 5;
  localparam int AW = FR + IN_W + 2;
  localparam int SH = FR - OUT_W;

  // Segment thresholds on |v| (IN_FRAC fractional bits)
  localparam logic [PW-1:0] P_1    = PW'(1)  << IN_FRAC;
  localparam logic [PW-1:0] P_2375 = PW'(19) << (IN_FRAC - 3);
  localparam logic [PW-1:0] P_5    = PW'(5)  << IN_FRAC;

  // Segment offsets with FR fractional bits
  localparam logic signed [AW-1:0] ONE    = AW'(1)  << FR;
  localparam logic signed [AW-1:0] C_HALF = AW'(1)  << (FR - 1);
  localparam logic signed [AW-1:0] C_0625 = AW'(5)  << (FR - 3);
  localparam logic signed [AW-1:0] C_0844 = AW'(27) << (FR - 5);

  // Output-scale constants for the signed tanh result
  localparam logic signed [AW-1:0] HALF_OUT = AW'(1) << (OUT_W - 1);
  localparam logic signed [AW-1:0] QMAX     = HALF_OUT - AW'(1);

  localparam logic signed [IN_W-1:0] X_2 = IN_W'(2) << IN_FRAC;
  localparam logic [IN_W+OUT_W-1:0]  OMAX_Z = {{IN_W{1'b0}}, {OUT_W{1'b1}}};

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- capture rank ----------------
  logic            r0_valid;
  logic [IN_W-1:0] r0_x;
  logic [1:0]      r0_mode;

  // Capture the accepted sample together with its mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_valid <= 1'b0;
      r0_x     <= '0;
      r0_mode  <= '0;
    end else if (en) begin
      r0_valid <= in_valid;
      r0_x     <= in_data;
      r0_mode  <= in_mode;
    end
  end

  // ---------------- S1: |v|, sign, segment, flags ----------------
  logic [PW-1:0]          xe, v, p;
  logic                   neg;
  logic [1:0]             seg;
  logic                   sat1, sat2, sat3;
  logic [OUT_W-1:0]       r3;
  logic [IN_W+OUT_W-1:0]  xz;
  logic signed [IN_W-1:0] xs;

  // Form v, its magnitude and segment; precompute the ReLU result and flags
  always_comb begin
    xs  = $signed(r0_x);
    xe  = {{2{r0_x[IN_W-1]}}, r0_x};
    v   = (r0_mode == M_TANH) ? (xe << 1) : xe;
    neg = v[PW-1];
    p   = neg ? ((~v) + PW'(1)) : v;
    if (p >= P_5)         seg = 2'd3;
    else if (p >= P_2375) seg = 2'd2;
    else if (p >= P_1)    seg = 2'd1;
    else                  seg = 2'd0;
    sat2 = (xs >= X_2) || (xs <= -X_2);
    xz   = {{OUT_W{1'b0}}, r0_x};
    r3   = '0;
    sat3 = 1'b0;
    if (r0_x[IN_W-1]) begin
      r3   = '0;
      sat3 = 1'b1;
    end else if (xz > OMAX_Z) begin
      r3   = '1;
      sat3 = 1'b1;
    end else begin
      r3   = OUT_W'(xz);
    end
    case (r0_mode)
      M_HSIG:  sat1 = sat2;
      M_RELU:  sat1 = sat3;
      default: sat1 = (seg == 2'd3);
    endcase
  end

  logic             r1_valid, r1_neg, r1_sat;
  logic [1:0]       r1_mode, r1_seg;
  logic [PW-1:0]    r1_p;
  logic [IN_W-1:0]  r1_x;
  logic [OUT_W-1:0] r1_r3;

  // S1 register rank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_neg   <= 1'b0;
      r1_sat   <= 1'b0;
      r1_mode  <= '0;
      r1_seg   <= '0;
      r1_p     <= '0;
      r1_x     <= '0;
      r1_r3    <= '0;
    end else if (en) begin
      r1_valid <= r0_valid;
      r1_neg   <= neg;
      r1_sat   <= sat1;
      r1_mode  <= r0_mode;
      r1_seg   <= seg;
      r1_p     <= p;
      r1_x     <= r0_x;
      r1_r3    <= r3;
    end
  end

  // ---------------- S2: segment multiply-add ----------------
  logic signed [AW-1:0] pz, xa, acc;

  // Exact shift-and-add of the selected segment (or the hard-sigmoid line)
  always_comb begin
    pz = {{(AW-PW){1'b0}}, r1_p};
    xa = {{(AW-IN_W){r1_x[IN_W-1]}}, r1_x};
    if (r1_mode == M_HSIG) begin
      acc = (xa <<< (OUT_W + 3)) + C_HALF;
    end else begin
      case (r1_seg)
        2'd0:    acc = (pz << (OUT_W + 3)) + C_HALF;
        2'd1:    acc = (pz << (OUT_W + 2)) + C_0625;
        2'd2:    acc = (pz << OUT_W) + C_0844;
        default: acc = ONE;
      endcase
    end
  end

  logic                 r2_valid, r2_neg, r2_sat;
  logic [1:0]           r2_mode;
  logic signed [AW-1:0] r2_acc;
  logic [OUT_W-1:0]     r2_r3;

  // S2 register rank
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_neg   <= 1'b0;
      r2_sat   <= 1'b0;
      r2_mode  <= '0;
      r2_acc   <= '0;
      r2_r3    <= '0;
    end else if (en) begin
      r2_valid <= r1_valid;
      r2_neg   <= r1_neg;
      r2_sat   <= r1_sat;
      r2_mode  <= r1_mode;
      r2_acc   <= acc;
      r2_r3    <= r1_r3;
    end
  end

  // ---------------- S3: symmetry, rescale, clamp ----------------
  logic signed [AW-1:0] y, ys, q, qc;
  logic [OUT_W-1:0]     res;

  // Mirror negative sigmoid inputs, floor to the output scale and clamp
  always_comb begin
    if ((r2_mode == M_SIG || r2_mode == M_TANH) && r2_neg) y = ONE - r2_acc;
    else                                                   y = r2_acc;
    ys = y >>> SH;
    q  = ys - HALF_OUT;
    if (q > QMAX)       qc = QMAX;
    else if (q < -QMAX) qc = -QMAX;
    else                qc = q;
    case (r2_mode)
      M_TANH: res = OUT_W'(qc);
      M_RELU: res = r2_r3;
      default: begin
        if (y < 0)         res = '0;
        else if (y >= ONE) res = '1;
        else               res = OUT_W'(ys);
      end
    endcase
  end

  // Output register; data is only replaced by real samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        out_data <= res;
        out_sat  <= r2_sat;
      end
    end
  end

endmodule

// File: tb/tb_pwl_activation_pipe.sv
// Directed bench for pwl_activation_pipe: per-mode vectors, backpressure,
// reset flush, a second parameter set and a randomized handshake run.
module tb_pwl_activation_pipe;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_sat;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_in_mode;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_sat;
  logic [11:0] b_in_data, b_out_data;
  logic [1:0]  b_in_mode;

  pwl_activation_pipe #(.IN_W(8), .IN_FRAC(4), .OUT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat)
  );

  pwl_activation_pipe #(.IN_W(12), .IN_FRAC(6), .OUT_W(12)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vector list for instance A
  logic [7:0] vd [32];
  logic [1:0] vm [32];
  logic [7:0] ed [32];
  logic       es [32];
  int         nv = 0;

  task automatic add(input logic [1:0] m, input logic [7:0] d, input logic [7:0] e, input logic s);
    vd[nv] = d; vm[nv] = m; ed[nv] = e; es[nv] = s;
    nv++;
  endtask

  // Issue the list back-to-back; each result must appear exactly 3 edges later
  task automatic stream(input string pfx);
    for (int c = 0; c < nv + 3; c++) begin
      a_in_valid = (c < nv);
      if (c < nv) begin
        a_in_data = vd[c];
        a_in_mode = vm[c];
      end
      tick();
      if (c >= 3) begin
        chk($sformatf("%s[%0d].valid", pfx, c-3), 32'(a_out_valid), 32'(1));
        chk($sformatf("%s[%0d].data", pfx, c-3), 32'(a_out_data), 32'(ed[c-3]));
        chk($sformatf("%s[%0d].sat", pfx, c-3), 32'(a_out_sat), 32'(es[c-3]));
      end else begin
        chk($sformatf("%s.lat%0d", pfx, c), 32'(a_out_valid), 32'(0));
      end
    end
    a_in_valid = 1'b0;
    nv = 0;
  endtask

  // Real-arithmetic reference for IN_W=8, IN_FRAC=4, OUT_W=8: {sat, data}
  function automatic logic [8:0] model(input logic [7:0] d, input logic [1:0] m);
    real x, v, p, yp, y;
    int  r;
    logic s;
    x = $itor($signed(d)) / 16.0;
    r = 0;
    s = 1'b0;
    if (m == 2'd0 || m == 2'd1) begin
      v = (m == 2'd1) ? 2.0 * x : x;
      p = (v < 0.0) ? -v : v;
      if (p >= 5.0)        yp = 1.0;
      else if (p >= 2.375) yp = p / 32.0 + 0.84375;
      else if (p >= 1.0)   yp = p / 8.0 + 0.625;
      else                 yp = p / 4.0 + 0.5;
      y = (v < 0.0) ? 1.0 - yp : yp;
      s = (p >= 5.0);
      r = $rtoi($floor(y * 256.0));
      if (m == 2'd0) begin
        if (r > 255) r = 255;
      end else begin
        r = r - 128;
        if (r > 127)  r = 127;
        if (r < -127) r = -127;
      end
    end else if (m == 2'd2) begin
      y = x / 4.0 + 0.5;
      if (y < 0.0) y = 0.0;
      if (y > 1.0) y = 1.0;
      r = $rtoi($floor(y * 256.0));
      if (r > 255) r = 255;
      s = (x >= 2.0) || (x <= -2.0);
    end else begin
      if (x < 0.0) begin
        r = 0;
        s = 1'b1;
      end else begin
        r = int'(d);
      end
    end
    return {s, 8'(r)};
  endfunction

  logic [11:0] bd [3] = '{12'h000, 12'hFC0, 12'h200};
  logic [1:0]  bm [3] = '{2'd0, 2'd0, 2'd1};
  logic [11:0] be [3] = '{12'd2048, 12'd1024, 12'd2047};
  logic        bs [3] = '{1'b0, 1'b0, 1'b1};

  localparam int NR = 2000;
  logic [8:0] q [$];
  logic [8:0] prev, expv;
  logic       pend, hold;
  int         got, sent, cyc;

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst.out_valid", 32'(a_out_valid), 32'(0));
    chk("rst.out_data", 32'(a_out_data), 32'(0));
    chk("rst.out_sat", 32'(a_out_sat), 32'(0));
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(a_in_ready), 32'(1));

    // Mode 0 sigmoid, including segment boundaries and saturation
    add(2'd0, 8'h00, 8'd128, 1'b0);
    add(2'd0, 8'h08, 8'd160, 1'b0);
    add(2'd0, 8'hF8, 8'd96,  1'b0);
    add(2'd0, 8'h10, 8'd192, 1'b0);
    add(2'd0, 8'h26, 8'd235, 1'b0);
    add(2'd0, 8'h30, 8'd240, 1'b0);
    add(2'd0, 8'h4F, 8'd255, 1'b0);
    add(2'd0, 8'h50, 8'd255, 1'b1);
    add(2'd0, 8'h80, 8'd0,   1'b1);
    add(2'd0, 8'h7F, 8'd255, 1'b1);
    stream("m0");

    // Mode 1 tanh
    add(2'd1, 8'h00, 8'h00, 1'b0);
    add(2'd1, 8'h08, 8'h40, 1'b0);
    add(2'd1, 8'hF8, 8'hC0, 1'b0);
    add(2'd1, 8'h30, 8'h7F, 1'b1);
    add(2'd1, 8'h80, 8'h81, 1'b1);
    stream("m1");

    // Modes 2 and 3 interleaved sample by sample
    add(2'd2, 8'h04, 8'd144, 1'b0);
    add(2'd3, 8'h7F, 8'h7F,  1'b0);
    add(2'd2, 8'h10, 8'd192, 1'b0);
    add(2'd3, 8'hF0, 8'h00,  1'b1);
    add(2'd2, 8'h20, 8'd255, 1'b1);
    add(2'd0, 8'h08, 8'd160, 1'b0);
    add(2'd2, 8'hE0, 8'd0,   1'b1);
    stream("m23");

    // Backpressure: three samples in flight, downstream stalls
    a_in_mode = 2'd0;
    a_in_valid = 1'b1; a_in_data = 8'h08; tick();
    a_in_data = 8'h10; tick();
    a_in_data = 8'h30; tick();
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    tick();
    chk("bp.first_valid", 32'(a_out_valid), 32'(1));
    chk("bp.first_data", 32'(a_out_data), 32'(160));
    chk("bp.in_ready_low", 32'(a_in_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp.hold%0d.valid", i), 32'(a_out_valid), 32'(1));
      chk($sformatf("bp.hold%0d.data", i), 32'(a_out_data), 32'(160));
      chk($sformatf("bp.hold%0d.in_ready", i), 32'(a_in_ready), 32'(0));
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp.in_ready_comb", 32'(a_in_ready), 32'(1));
    tick();
    chk("bp.drain1.valid", 32'(a_out_valid), 32'(1));
    chk("bp.drain1.data", 32'(a_out_data), 32'(192));
    tick();
    chk("bp.drain2.valid", 32'(a_out_valid), 32'(1));
    chk("bp.drain2.data", 32'(a_out_data), 32'(240));
    tick();
    chk("bp.drain_end", 32'(a_out_valid), 32'(0));

    // Reset with two samples in flight: nothing may emerge afterwards
    a_in_valid = 1'b1; a_in_data = 8'h50; tick();
    a_in_data = 8'h26; tick();
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mid_rst.out_valid", 32'(a_out_valid), 32'(0));
    chk("mid_rst.out_data", 32'(a_out_data), 32'(0));
    chk("mid_rst.out_sat", 32'(a_out_sat), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("mid_rst.in_ready", 32'(a_in_ready), 32'(1));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mid_rst.flushed%0d", i), 32'(a_out_valid), 32'(0));
    end

    // Second parameter set (IN_W=12, IN_FRAC=6, OUT_W=12)
    for (int c = 0; c < 6; c++) begin
      b_in_valid = (c < 3);
      if (c < 3) begin
        b_in_data = bd[c];
        b_in_mode = bm[c];
      end
      tick();
      if (c >= 3) begin
        chk($sformatf("b[%0d].valid", c-3), 32'(b_out_valid), 32'(1));
        chk($sformatf("b[%0d].data", c-3), 32'(b_out_data), 32'(be[c-3]));
        chk($sformatf("b[%0d].sat", c-3), 32'(b_out_sat), 32'(bs[c-3]));
      end
    end
    b_in_valid = 1'b0;

    // Randomized valid/ready run against the reference model
    got = 0; sent = 0; cyc = 0; pend = 1'b0; hold = 1'b0; prev = '0;
    while (got < NR && cyc < 40 * NR) begin
      if (!pend) begin
        a_in_valid = ($urandom_range(3) != 0) && (sent < NR);
        a_in_data  = 8'($urandom);
        a_in_mode  = 2'($urandom);
      end
      a_out_ready = ($urandom_range(3) != 0);
      #1;
      if (hold) chk("rand.stable", 32'({a_out_valid, a_out_sat, a_out_data}), 32'({1'b1, prev}));
      if (a_out_valid && a_out_ready) begin
        if (q.size() == 0) begin
          chk("rand.spurious", 32'(1), 32'(0));
        end else begin
          expv = q.pop_front();
          chk($sformatf("rand[%0d]", got), 32'({a_out_sat, a_out_data}), 32'(expv));
        end
        got++;
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back(model(a_in_data, a_in_mode));
        sent++;
        pend = 1'b0;
      end else begin
        pend = a_in_valid;
      end
      hold = a_out_valid && !a_out_ready;
      prev = {a_out_sat, a_out_data};
      tick();
      cyc++;
    end
    chk("rand.count", 32'(got), 32'(NR));
    a_in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
